pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage RV32 pipeline: PC, IF/ID, ID/EX, EX/MEM and MEM/WB latches.
- Detects load-use hazards at ID, squashes wrong-path instructions on a taken branch resolved at MEM, and freezes the pipe while data memory is not ready.
- A wait FSM with a timeout halts the core if memory never responds.
- Also keeps saturating stall and flush performance counters.

---
 rtl/pipeline_hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken-branch squash,
// memory-wait freeze with timeout halt, and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             mem_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             exmem_stall,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {StRun, StWait, StHalt} state_e;

  // Only meaningful when MEM_TIMEOUT != 0; the compare is gated on that below.
  localparam logic [15:0] TimeoutLast = 16'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [15:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cycles_q, flush_count_q;
  logic              freeze;
  logic              lu_hazard;

  assign freeze    = mem_req & ~mem_ready;
  assign lu_hazard = ex_memread & (ex_rd != 5'd0) &
                     ((id_use_rs1 & (ex_rd == id_rs1)) | (id_use_rs2 & (ex_rd == id_rs2)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StRun: begin
        if (freeze) begin
          state_d    = StWait;
          wait_cnt_d = 16'd1;
        end else begin
          wait_cnt_d = '0;
        end
      end
      StWait: begin
        if (!freeze) begin
          state_d    = StRun;
          wait_cnt_d = '0;
        end else if ((MEM_TIMEOUT != 0) && (wait_cnt_q == TimeoutLast)) begin
          state_d = StHalt;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      StHalt: ;
      default: state_d = StRun;
    endcase
  end

  // Priority: halt, freeze, taken branch, load-use. Reset forces everything low.
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    exmem_stall = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    halted      = 1'b0;
    if (!reset) begin
      if (state_q == StHalt || freeze) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_stall  = 1'b1;
        exmem_stall = 1'b1;
        memwb_flush = 1'b1;
        halted      = (state_q == StHalt);
      end else if (mem_branch_taken) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (lu_hazard) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (pc_stall && (stall_cycles_q != '1)) begin
        stall_cycles_q <= stall_cycles_q + CNT_W'(1);
      end
      if (ifid_flush && exmem_flush && (flush_count_q != '1)) begin
        flush_count_q <= flush_count_q + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus random
// stimulus against a streak-counting behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned TO  = 4;
  localparam int unsigned CW  = 4;
  localparam int          MAX = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_use_rs1, id_use_rs2, ex_memread;
  logic          mem_branch_taken, mem_req, mem_ready;
  logic          pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic          exmem_stall, exmem_flush, memwb_flush, halted;
  logic [CW-1:0] stall_cycles, flush_count;

  int total;
  int bad;

  // Model state: halted flag, consecutive-freeze streak, counters.
  bit m_halted;
  int m_streak;
  int m_stall;
  int m_flush;

  // {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
  //  exmem_stall, exmem_flush, memwb_flush, halted}
  logic [8:0] act;
  assign act = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
                exmem_stall, exmem_flush, memwb_flush, halted};

  localparam logic [8:0] OutFreeze = 9'b110101010;
  localparam logic [8:0] OutHalt   = 9'b110101011;
  localparam logic [8:0] OutBranch = 9'b001010100;
  localparam logic [8:0] OutLu     = 9'b110010000;

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT(TO),
    .CNT_W      (CW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .ex_memread      (ex_memread),
    .ex_rd           (ex_rd),
    .mem_branch_taken(mem_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_stall        (pc_stall),
    .ifid_stall      (ifid_stall),
    .ifid_flush      (ifid_flush),
    .idex_stall      (idex_stall),
    .idex_flush      (idex_flush),
    .exmem_stall     (exmem_stall),
    .exmem_flush     (exmem_flush),
    .memwb_flush     (memwb_flush),
    .halted          (halted),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] exp_out();
    bit frz, lu;
    frz = mem_req && !mem_ready;
    lu  = ex_memread && (ex_rd != 0) &&
          ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
    if (reset)            return 9'b0;
    if (m_halted)         return OutHalt;
    if (frz)              return OutFreeze;
    if (mem_branch_taken) return OutBranch;
    if (lu)               return OutLu;
    return 9'b0;
  endfunction

  function automatic int sat_inc(int v);
    return (v >= MAX) ? MAX : v + 1;
  endfunction

  // Advance one clock and update the model from the inputs seen at that edge.
  task automatic tick();
    logic [8:0] o;
    bit frz;
    o   = exp_out();
    frz = mem_req && !mem_ready;
    @(posedge clk);
    if (reset) begin
      m_halted = 0;
      m_streak = 0;
      m_stall  = 0;
      m_flush  = 0;
    end else begin
      if (o[8]) m_stall = sat_inc(m_stall);
      if (o[6] && o[2]) m_flush = sat_inc(m_flush);
      if (!m_halted) begin
        if (frz) begin
          m_streak++;
          if (TO != 0 && m_streak >= TO) m_halted = 1;
        end else begin
          m_streak = 0;
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_memread = 0; ex_rd = 0; mem_branch_taken = 0; mem_req = 0; mem_ready = 1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic set_lu(input logic [4:0] rd);
    ex_memread = 1; ex_rd = rd; id_rs2 = 5; id_use_rs2 = 1; id_rs1 = 7; id_use_rs1 = 1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1; mem_req = 1; mem_ready = 0; mem_branch_taken = 1;
    #1;
    total++;
    if (act !== 9'b0) begin
      bad++; $display("FAIL reset_outputs: got %b want %b", act, 9'b0);
    end
    tick();
    reset = 0;
    idle();
    #1;
    total++;
    if (act !== 9'b0 || stall_cycles !== 0 || flush_count !== 0) begin
      bad++;
      $display("FAIL post_reset: got out=%b stall=%0d flush=%0d want 0/0/0",
               act, stall_cycles, flush_count);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_lu(5);
    #1;
    total++;
    if (act !== OutLu || act !== exp_out()) begin
      bad++; $display("FAIL load_use: got %b want %b", act, OutLu);
    end
    tick();
    idle();
    #1;
    total++;
    if (act !== 9'b0 || stall_cycles !== 1 || m_stall != 1) begin
      bad++; $display("FAIL load_use_after: got out=%b stall=%0d want 0/1", act, stall_cycles);
    end
    set_lu(0);
    #1;
    total++;
    if (act !== 9'b0) begin
      bad++; $display("FAIL load_use_x0: got %b want %b", act, 9'b0);
    end
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    set_lu(5);
    mem_branch_taken = 1;
    #1;
    total++;
    if (act !== OutBranch) begin
      bad++; $display("FAIL branch_over_lu: got %b want %b", act, OutBranch);
    end
    tick();
    idle();
    #1;
    total++;
    if (flush_count !== 1 || stall_cycles !== 0) begin
      bad++;
      $display("FAIL branch_count: got flush=%0d stall=%0d want 1/0", flush_count, stall_cycles);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (act !== OutFreeze) begin
        bad++; $display("FAIL mem_wait_c%0d: got %b want %b", i + 1, act, OutFreeze);
      end
      tick();
    end
    mem_ready = 1;
    #1;
    total++;
    if (act !== 9'b0) begin
      bad++; $display("FAIL mem_wait_release: got %b want %b", act, 9'b0);
    end
    tick();
    idle();
    #1;
    total++;
    if (stall_cycles !== 3 || halted !== 0) begin
      bad++; $display("FAIL mem_wait_count: got stall=%0d halted=%b want 3/0", stall_cycles, halted);
    end
  endtask

  task automatic test_freeze_branch();
    do_reset();
    mem_branch_taken = 1; mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (act !== OutFreeze) begin
        bad++; $display("FAIL frz_br_c%0d: got %b want %b", i + 1, act, OutFreeze);
      end
      tick();
    end
    mem_ready = 1;
    #1;
    total++;
    if (act !== OutBranch) begin
      bad++; $display("FAIL frz_br_c3: got %b want %b", act, OutBranch);
    end
    tick();
    idle();
    #1;
    total++;
    if (stall_cycles !== 2 || flush_count !== 1) begin
      bad++;
      $display("FAIL frz_br_count: got stall=%0d flush=%0d want 2/1", stall_cycles, flush_count);
    end
  endtask

  task automatic test_timeout();
    logic [8:0] want;
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int c = 1; c <= 7; c++) begin
      #1;
      want = (c >= TO + 1) ? OutHalt : OutFreeze;
      total++;
      if (act !== want) begin
        bad++; $display("FAIL timeout_c%0d: got %b want %b", c, act, want);
      end
      tick();
    end
    mem_ready = 1;
    for (int c = 0; c < 2; c++) begin
      #1;
      total++;
      if (act !== OutHalt) begin
        bad++; $display("FAIL halt_sticky_%0d: got %b want %b", c, act, OutHalt);
      end
      tick();
    end
    reset = 1;
    #1;
    total++;
    if (act !== 9'b0) begin
      bad++; $display("FAIL halt_in_reset: got %b want %b", act, 9'b0);
    end
    tick();
    reset = 0;
    idle();
    #1;
    total++;
    if (act !== 9'b0 || stall_cycles !== 0 || flush_count !== 0) begin
      bad++;
      $display("FAIL halt_cleared: got out=%b stall=%0d flush=%0d want 0/0/0",
               act, stall_cycles, flush_count);
    end
  endtask

  task automatic test_saturation();
    int want;
    do_reset();
    set_lu(5);
    for (int i = 1; i <= 20; i++) begin
      tick();
      #1;
      want = (i > MAX) ? MAX : i;
      total++;
      if (stall_cycles !== CW'(want) || m_stall != want) begin
        bad++; $display("FAIL sat_%0d: got %0d want %0d", i, stall_cycles, want);
      end
    end
    idle();
  endtask

  task automatic test_random();
    logic [8:0] want;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset            = ($urandom_range(0, 39) == 0);
      id_rs1           = 5'($urandom_range(0, 3));
      id_rs2           = 5'($urandom_range(0, 3));
      id_use_rs1       = 1'($urandom);
      id_use_rs2       = 1'($urandom);
      ex_memread       = 1'($urandom);
      ex_rd            = 5'($urandom_range(0, 3));
      mem_branch_taken = ($urandom_range(0, 3) == 0);
      mem_req          = 1'($urandom);
      mem_ready        = ($urandom_range(0, 3) != 0);
      if (i >= 200 && i < 210) begin
        reset = 0; mem_req = 1; mem_ready = 0;
      end
      #1;
      want = exp_out();
      total++;
      if (act !== want || stall_cycles !== CW'(m_stall) || flush_count !== CW'(m_flush)) begin
        bad++;
        $display("FAIL rand_%0d: got out=%b s=%0d f=%0d want out=%b s=%0d f=%0d",
                 i, act, stall_cycles, flush_count, want, m_stall, m_flush);
      end
      tick();
    end
    reset = 0;
    idle();
  endtask

  initial begin
    total = 0; bad = 0;
    m_halted = 0; m_streak = 0; m_stall = 0; m_flush = 0;
    idle();
    reset = 1;
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_freeze_branch();
    test_timeout();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
